// File: rtl/ee357_2x32_mux.sv
// 2-to-1 word multiplexer with a combinational result and a registered copy.
// Used for operand and next-PC selection in the multicycle CPU.
module ee357_2x32_mux #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] zero,
    input  logic [WIDTH-1:0] one,
    input  logic             sel,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q
);

    logic [WIDTH-1:0] w_out;
    logic [WIDTH-1:0] r_out_q;

    // An unknown select yields all-X rather than silently favouring one leg.
    always_comb begin
        w_out = {WIDTH{1'bx}};
        case (sel)
            1'b0:    w_out = zero;
            1'b1:    w_out = one;
            default: w_out = {WIDTH{1'bx}};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_q <= {WIDTH{1'b0}};
        end else begin
            r_out_q <= w_out;
        end
    end

    assign out   = w_out;
    assign out_q = r_out_q;

endmodule

// File: tb/tb_ee357_2x32_mux.sv
// Self-checking bench for ee357_2x32_mux: directed scenarios plus randomized traffic
// compared against a behavioural selection model.
module tb_ee357_2x32_mux;

    logic        clk;
    logic        rst_n;
    logic        clk_en;
    logic [31:0] zero;
    logic [31:0] one;
    logic        sel;
    logic [31:0] out;
    logic [31:0] out_q;

    int checks = 0;
    int errors = 0;

    ee357_2x32_mux #(
        .WIDTH(32)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .zero (zero),
        .one  (one),
        .sel  (sel),
        .out  (out),
        .out_q(out_q)
    );

    // Clock stays low until clk_en is raised, so the idle-clock tests see no edges.
    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    function automatic logic [31:0] pick(input logic [31:0] z, input logic [31:0] o,
                                         input logic s);
        if (s == 1'b1) return o;
        return z;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        zero  = 32'h0000_0001;
        one   = 32'h0000_0000;
        sel   = 1'b0;
        #2;
        checks++;
        if (out_q !== 32'h0) begin
            $display("FAIL reset_out_q: got %h, required %h", out_q, 32'h0);
            errors++;
        end
        checks++;
        if (out !== 32'h1) begin
            $display("FAIL reset_out_comb: got %h, required %h", out, 32'h1);
            errors++;
        end
        rst_n = 1'b1;
        #2;
    endtask

    task automatic test_comb_idle();
        zero = 32'h0000_0001; one = 32'h0000_0000; sel = 1'b0;
        #1;
        checks++;
        if (out !== 32'h1) begin
            $display("FAIL idle_sel0: got %h, required %h", out, 32'h1);
            errors++;
        end
        zero = 32'h0000_0000;
        #1;
        checks++;
        if (out !== 32'h0) begin
            $display("FAIL idle_zero_change: got %h, required %h", out, 32'h0);
            errors++;
        end
        zero = 32'h0000_0001; sel = 1'b1;
        #1;
        checks++;
        if (out !== 32'h0) begin
            $display("FAIL idle_sel1: got %h, required %h", out, 32'h0);
            errors++;
        end
        one = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (out !== 32'hDEAD_BEEF) begin
            $display("FAIL idle_one_change: got %h, required %h", out, 32'hDEAD_BEEF);
            errors++;
        end
        checks++;
        if (out_q !== 32'h0) begin
            $display("FAIL idle_out_q_hold: got %h, required %h", out_q, 32'h0);
            errors++;
        end
    endtask

    task automatic test_reset_release();
        rst_n = 1'b0;
        zero  = 32'hFFFF_FFFF;
        sel   = 1'b0;
        #1;
        checks++;
        if (out_q !== 32'h0) begin
            $display("FAIL rel_out_q_in_reset: got %h, required %h", out_q, 32'h0);
            errors++;
        end
        checks++;
        if (out !== 32'hFFFF_FFFF) begin
            $display("FAIL rel_out_in_reset: got %h, required %h", out, 32'hFFFF_FFFF);
            errors++;
        end
        rst_n  = 1'b1;
        #1;
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_q !== 32'hFFFF_FFFF) begin
            $display("FAIL rel_first_capture: got %h, required %h", out_q, 32'hFFFF_FFFF);
            errors++;
        end
    endtask

    task automatic test_alternate();
        logic [31:0] exp;
        zero = 32'hA5A5_A5A5;
        one  = 32'h5A5A_5A5A;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            sel = i[0];
            exp = pick(zero, one, sel);
            @(posedge clk);
            #1;
            checks++;
            if (out_q !== exp) begin
                $display("FAIL alt_out_q[%0d]: got %h, required %h", i, out_q, exp);
                errors++;
            end
        end
        // Reset asserted between edges must clear out_q at once, leaving out alone.
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        exp = pick(zero, one, sel);
        checks++;
        if (out_q !== 32'h0) begin
            $display("FAIL midreset_out_q: got %h, required %h", out_q, 32'h0);
            errors++;
        end
        checks++;
        if (out !== exp) begin
            $display("FAIL midreset_out: got %h, required %h", out, exp);
            errors++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_q !== 32'h0) begin
            $display("FAIL midreset_hold: got %h, required %h", out_q, 32'h0);
            errors++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_q !== exp) begin
            $display("FAIL midreset_recover: got %h, required %h", out_q, exp);
            errors++;
        end
    endtask

    task automatic test_sel_glitch();
        zero = 32'h1111_2222;
        one  = 32'h3333_4444;
        @(negedge clk);
        sel = 1'b0;
        #1;
        sel = 1'b1;
        #1;
        checks++;
        if (out !== 32'h3333_4444) begin
            $display("FAIL glitch_out_follow: got %h, required %h", out, 32'h3333_4444);
            errors++;
        end
        sel = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_q !== 32'h1111_2222) begin
            $display("FAIL glitch_edge_sample: got %h, required %h", out_q, 32'h1111_2222);
            errors++;
        end
    endtask

    task automatic test_equal_and_x();
        logic probe;
        zero = 32'h1234_5678;
        one  = 32'h1234_5678;
        for (int i = 0; i < 4; i++) begin
            sel = i[0];
            #1;
            checks++;
            if (out !== 32'h1234_5678) begin
                $display("FAIL equal_legs[%0d]: got %h, required %h", i, out, 32'h1234_5678);
                errors++;
            end
        end
        // Only meaningful on a four-state simulator; a two-state one cannot hold X.
        probe = 1'bx;
        if (probe === 1'bx) begin
            zero = 32'h0F0F_0F0F;
            one  = 32'hF0F0_F0F0;
            sel  = 1'bx;
            #1;
            checks++;
            if (out !== 32'hxxxx_xxxx) begin
                $display("FAIL sel_x: got %h, required all-X", out);
                errors++;
            end
            sel = 1'b0;
            #1;
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_q;
        logic [31:0] exp_c;
        @(negedge clk);
        exp_q = pick(zero, one, sel);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            zero = $urandom;
            one  = ($urandom_range(0, 7) == 0) ? zero : $urandom;
            sel  = 1'($urandom_range(0, 1));
            #1;
            exp_c = pick(zero, one, sel);
            checks++;
            if (out !== exp_c) begin
                $display("FAIL rand_out[%0d]: got %h, required %h", i, out, exp_c);
                errors++;
            end
            @(posedge clk);
            #1;
            checks++;
            if (out_q !== exp_c) begin
                $display("FAIL rand_out_q[%0d]: got %h, required %h", i, out_q, exp_c);
                errors++;
            end
            exp_q = exp_c;
        end
        checks++;
        if (out_q !== exp_q) begin
            $display("FAIL rand_final: got %h, required %h", out_q, exp_q);
            errors++;
        end
    endtask

    initial begin
        clk_en = 1'b0;
        test_reset();
        test_comb_idle();
        test_reset_release();
        test_alternate();
        test_sel_glitch();
        test_equal_and_x();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
